// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, the jump
// opcode, opcode-field extraction, offset sign-extension and the queue entry layout.
package ifetch_pkg;

  localparam int unsigned IW_DEF  = 8;
  localparam int unsigned PCW_DEF = 8;
  localparam int unsigned OPW_DEF = 2;
  localparam int unsigned XW      = 64;  // working width for the width-generic helpers

  localparam logic [OPW_DEF-1:0] JMP_OP_DEF = 2'b11;

  // Queue entry layout {pc, instr}; the queue stores the same concatenation
  // at whatever widths the fetch stage is built with.
  typedef struct packed {
    logic [PCW_DEF-1:0] pc;
    logic [IW_DEF-1:0]  instr;
  } fq_entry_t;

  // Opcode field instr[iw-1 -: opw], returned zero-extended.
  function automatic logic [XW-1:0] op_field(input logic [XW-1:0] instr,
                                              input int unsigned  iw  = IW_DEF,
                                              input int unsigned  opw = OPW_DEF);
    logic [XW-1:0] mask;
    mask = (XW'(1) << opw) - XW'(1);
    return (instr >> (iw - opw)) & mask;
  endfunction

  // Offset field instr[iw-opw-1:0], sign-extended to XW; callers truncate to PCW.
  function automatic logic [XW-1:0] sext_off(input logic [XW-1:0] instr,
                                              input int unsigned  iw  = IW_DEF,
                                              input int unsigned  opw = OPW_DEF);
    logic signed [XW-1:0] t;
    int unsigned          sh;
    sh = XW - (iw - opw);
    t  = signed'(instr << sh);
    return t >>> sh;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular-buffer FIFO with push, pop and flush.
// Ports: clk, rst_n (async active-low), push_i/din_i (write), pop_i (read head),
// flush_i (empty the queue), valid_o/dout_o (head, zero while empty), count_o.
// Pop is applied before push, so a push into a full queue succeeds when it pops.
module fetch_queue #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       valid_o,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok_c, push_ok_c;

  assign pop_ok_c  = pop_i & (count_q != '0);
  assign push_ok_c = push_i & ~flush_i & ((count_q != CW'(DEPTH)) | pop_ok_c);

  // Pointer/count update; flush overrides everything and rewinds the pointers.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_ok_c) mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_pipe.sv
// Instruction-fetch stage: PC register, fetch-time resolution of relative jumps,
// and a small queue of {pc, instr} entries feeding decode via valid/ready.
// Ports: clk, rst (async active-low); fetch_en; imem_addr/imem_data (combinational
// instruction memory); redir_valid/redir_pc (redirect from execute);
// if_valid/if_instr/if_pc/id_ready (decode handshake).
module ifetch_pipe
  import ifetch_pkg::*;
#(
  parameter int unsigned      IW       = IW_DEF,
  parameter int unsigned      PCW      = PCW_DEF,
  parameter int unsigned      OPW      = OPW_DEF,
  parameter logic [OPW-1:0]   JMP_OP   = OPW'(JMP_OP_DEF),
  parameter int unsigned      FQ_DEPTH = 2,
  parameter logic [PCW-1:0]   RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fetch_en,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  input  logic           redir_valid,
  input  logic [PCW-1:0] redir_pc,
  output logic           if_valid,
  output logic [IW-1:0]  if_instr,
  output logic [PCW-1:0] if_pc,
  input  logic           id_ready
);

  localparam int unsigned EW = PCW + IW;
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  logic [PCW-1:0] pc_q, pc_d;
  logic [PCW-1:0] off_c;
  logic [CW-1:0]  count_c;
  logic [EW-1:0]  head_c;
  logic           pop_c, full_c, fire_c, is_jmp_c;

  assign pop_c    = if_valid & id_ready;
  assign full_c   = (count_c == CW'(FQ_DEPTH));
  assign fire_c   = fetch_en & ~redir_valid & (~full_c | pop_c);
  assign is_jmp_c = (OPW'(op_field(XW'(imem_data), IW, OPW)) == JMP_OP);
  assign off_c    = PCW'(sext_off(XW'(imem_data), IW, OPW));

  // Next PC: redirect beats sequential/jump advance; hold when not firing.
  always_comb begin
    pc_d = pc_q;
    if (redir_valid) begin
      pc_d = redir_pc;
    end else if (fire_c) begin
      pc_d = pc_q + PCW'(1) + (is_jmp_c ? off_c : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign imem_addr = pc_q;

  fetch_queue #(
    .W     (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (fire_c),
    .din_i   ({pc_q, imem_data}),
    .pop_i   (pop_c),
    .flush_i (redir_valid),
    .valid_o (if_valid),
    .dout_o  (head_c),
    .count_o (count_c)
  );

  assign {if_pc, if_instr} = head_c;

endmodule
